de2_115_sd_out_pio: RTL and testbench

Avalon-MM slave output port that drives the SD-card control lines (clock, command, chip-select) from the Nios II. It is the write-direction counterpart of the card-status input ports on the same bus. It provides a read/write data register, atomic bit set/clear registers, and a hardware burst generator that emits N clock pulses on `out_port[0]` at a programmable rate, so the CPU does not have to bit-bang the SD clock.

---
 rtl/de2_115_sd_pio_pkg.sv | 19 +
 rtl/de2_115_sd_pulse_burst.sv | 74 +++++++
 rtl/de2_115_sd_out_pio.sv | 91 +++++++++
 tb/tb_de2_115_sd_out_pio.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/de2_115_sd_pio_pkg.sv
// Shared constants and types for the SD-card PIO ports: register word addresses,
// burst FSM state encoding and burst counter width. No logic, no latency.
package de2_115_sd_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIV    = 3'd1;
    localparam logic [2:0] ADDR_BURST  = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int BURST_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } burst_state_e;

endpackage

// File: rtl/de2_115_sd_pulse_burst.sv
// Emits N pulses, each DIV+1 cycles high then DIV+1 low; pulse starts the edge after start.
// No backpressure: start is ignored while busy or when N is zero.
module de2_115_sd_pulse_burst
    import de2_115_sd_pio_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [BURST_CNT_W-1:0] n_i,
    input  logic [DIV_WIDTH-1:0]   div_i,
    output logic                   busy_o,
    output logic [BURST_CNT_W-1:0] remaining_o,
    output logic                   pulse_out_o
);

    burst_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0]   phase_q, phase_d;
    logic [BURST_CNT_W-1:0] rem_q, rem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
        end
    end

    // Divider is re-sampled at every phase start so DIV writes apply to the next phase.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && (n_i != '0)) begin
                    state_d = ST_HIGH;
                    rem_d   = n_i;
                    phase_d = div_i;
                end
            end
            ST_HIGH: begin
                if (phase_q == '0) begin
                    state_d = ST_LOW;
                    phase_d = div_i;
                end else begin
                    phase_d = phase_q - DIV_WIDTH'(1);
                end
            end
            ST_LOW: begin
                if (phase_q == '0) begin
                    rem_d   = rem_q - BURST_CNT_W'(1);
                    phase_d = div_i;
                    state_d = (rem_q == BURST_CNT_W'(1)) ? ST_IDLE : ST_HIGH;
                end else begin
                    phase_d = phase_q - DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign remaining_o = rem_q;
    assign pulse_out_o = (state_q == ST_HIGH);

endmodule

// File: rtl/de2_115_sd_out_pio.sv
// Avalon-MM output PIO for SD clock/cmd/cs with set/clear and a hardware clock-burst engine.
// Writes take effect one edge later, reads are registered (1 cycle); never stalls the bus.
module de2_115_sd_out_pio
    import de2_115_sd_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          DIV_WIDTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]       data_q, data_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   wr_en;
    logic                   burst_start;
    logic                   burst_busy;
    logic                   burst_pulse;
    logic [BURST_CNT_W-1:0] burst_rem;

    assign wr_en       = chipselect & ~write_n;
    assign burst_start = wr_en && (address == ADDR_BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            div_q      <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            div_q      <= div_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        data_d = data_q;
        div_d  = div_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = writedata[WIDTH-1:0];
                ADDR_DIV:    div_d  = writedata[DIV_WIDTH-1:0];
                ADDR_OUTSET: data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLR: data_d = data_q & ~writedata[WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible yet.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:  readdata_d[WIDTH-1:0]     = data_q;
            ADDR_DIV:   readdata_d[DIV_WIDTH-1:0] = div_q;
            ADDR_BURST: readdata_d = {burst_busy, 15'b0, burst_rem};
            default:    ;
        endcase
    end

    de2_115_sd_pulse_burst #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_burst (
        .clk         (clk),
        .reset       (reset),
        .start_i     (burst_start),
        .n_i         (writedata[BURST_CNT_W-1:0]),
        .div_i       (div_q),
        .busy_o      (burst_busy),
        .remaining_o (burst_rem),
        .pulse_out_o (burst_pulse)
    );

    always_comb begin
        out_port = data_q;
        if (burst_busy) begin
            out_port[0] = burst_pulse;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_de2_115_sd_out_pio.sv
// Bench for de2_115_sd_out_pio: directed scenarios plus random bus traffic,
// every cycle compared against a phase-indexed reference model.
module tb_de2_115_sd_out_pio;

    localparam int          W  = 8;
    localparam logic [31:0] RV = 32'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] out_port;

    always #5 clk = ~clk;

    de2_115_sd_out_pio #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .DIV_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: burst described as a sequence of phases k = 0..2N-1,
    // even phases high; each phase lasts (DIV at its start)+1 cycles.
    logic [7:0]  m_data;
    logic [7:0]  m_div;
    bit          m_busy;
    int          m_n;
    int          m_k;
    int          m_cyc;
    int          m_len;
    logic [31:0] m_rd;

    function automatic logic [15:0] m_rem();
        if (!m_busy) return 16'd0;
        return 16'(m_n - m_k / 2);
    endfunction

    function automatic logic [31:0] m_out();
        logic [7:0] o;
        o = m_data;
        if (m_busy) o[0] = (m_k % 2 == 0);
        return {24'd0, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_edge();
        logic [31:0] rd;
        logic [7:0]  div_pre;
        bit          busy_pre;
        rd = 32'd0;
        case (address)
            3'd0: rd = {24'd0, m_data};
            3'd1: rd = {24'd0, m_div};
            3'd2: rd = {m_busy, 15'd0, m_rem()};
            default: rd = 32'd0;
        endcase
        if (reset) begin
            m_data = RV[7:0];
            m_div  = 8'd0;
            m_busy = 0;
            m_n = 0; m_k = 0; m_cyc = 0; m_len = 0;
            m_rd = 32'd0;
        end else begin
            m_rd     = rd;
            busy_pre = m_busy;
            div_pre  = m_div;
            if (m_busy) begin
                m_cyc++;
                if (m_cyc == m_len) begin
                    m_k++;
                    m_cyc = 0;
                    m_len = int'(div_pre) + 1;
                    if (m_k == 2 * m_n) m_busy = 0;
                end
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_div  = writedata[7:0];
                    3'd2: if (!busy_pre && writedata[15:0] != 16'd0) begin
                        m_busy = 1;
                        m_n    = int'(writedata[15:0]);
                        m_k    = 0;
                        m_cyc  = 0;
                        m_len  = int'(div_pre) + 1;
                    end
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] wd);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out_port", {24'd0, out_port}, m_out());
        chk("readdata", readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b0, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    initial begin
        int hi;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        @(negedge clk);

        cyc(1'b1, 1'b0, 1'b1, 3'd2, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 3'd2, 32'd0);
        chk("rst_out", {24'd0, out_port}, RV);
        chk("rst_rd", readdata, 32'd0);
        rd(3'd2);
        chk("rst_burst", readdata, 32'd0);

        wr(3'd0, 32'h0F);
        chk("data_0f", {24'd0, out_port}, 32'h0F);
        wr(3'd4, 32'h30);
        chk("outset", {24'd0, out_port}, 32'h3F);
        wr(3'd5, 32'h03);
        chk("outclr", {24'd0, out_port}, 32'h3C);
        rd(3'd0);
        chk("rd_data", readdata, 32'h3C);

        wr(3'd1, 32'd2);
        wr(3'd2, 32'd3);
        hi = (out_port[0] === 1'b1) ? 1 : 0;
        for (int i = 0; i < 22; i++) begin
            rd(3'd2);
            if (out_port[0] === 1'b1) hi++;
        end
        chk("burst_hi_cycles", 32'(hi), 32'd9);
        chk("burst_done", readdata, 32'd0);

        wr(3'd2, 32'd0);
        rd(3'd2);
        chk("n0_noop", readdata, 32'd0);

        wr(3'd1, 32'd1);
        wr(3'd2, 32'd2);
        wr(3'd2, 32'd5);
        for (int i = 0; i < 10; i++) rd(3'd2);

        wr(3'd2, 32'd2);
        idle(1);
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h3D);
        for (int i = 0; i < 24; i++) rd(3'd2);
        chk("data0_after_burst", {31'd0, out_port[0]}, 32'd1);

        wr(3'd1, 32'd2);
        wr(3'd2, 32'd4);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 3'd2, 32'd0);
        chk("rst_mid_out", {24'd0, out_port}, RV);
        rd(3'd2);
        chk("rst_mid_rd", readdata, 32'd0);
        wr(3'd2, 32'd1);
        for (int i = 0; i < 8; i++) rd(3'd2);

        for (int i = 0; i < 2500; i++) begin
            bit          r_rst;
            logic [2:0]  a;
            logic [31:0] d;
            r_rst = ($urandom_range(0, 199) == 0);
            a     = 3'($urandom_range(0, 7));
            d     = $urandom;
            if (a == 3'd1) d = 32'($urandom_range(0, 3));
            if (a == 3'd2) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
            cyc(r_rst, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
